// File: rtl/pps_fold_fir_pkg.sv
// pps_fold_fir_pkg: shared coefficients, FSM states and sizing helpers for the folded FIR.
// Latency: none (declarations only).
// Backpressure: none.
package pps_fold_fir_pkg;

    localparam int NHALF_MAX = 11;
    localparam int COEF_W    = 18;
    localparam int HIDX_W    = $clog2(NHALF_MAX);

    typedef logic signed [COEF_W-1:0] coef_t;

    // Unique half of a 21-tap SRRC response in 1s17; the last entry is the centre tap.
    // Shorter filters take the entries nearest the centre.
    localparam coef_t COEF_H [0:NHALF_MAX-1] = '{
        -18'sd372,  18'sd1123,  18'sd2261,  18'sd1407, -18'sd1805, -18'sd5448,
        -18'sd6116, 18'sd0,     18'sd13524, 18'sd28627, 18'sd35282
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nhalf(input int ntaps);
        return (ntaps + 1) / 2;
    endfunction

    function automatic int acc_w(input int dw, input int cw, input int guard);
        return dw + cw + 1 + guard;
    endfunction

    // Out-of-range indices read as zero so an oversize filter degrades to zero taps.
    function automatic coef_t coef_at(input int idx);
        if (idx < 0 || idx >= NHALF_MAX) begin
            return '0;
        end
        return COEF_H[HIDX_W'(idx)];
    endfunction

endpackage

// File: rtl/pps_fold_fir_mac.sv
// pps_fold_fir_mac: pre-adder, shared multiplier and accumulator for one folded tap per cycle.
// Latency: fold presented in cycle n lands in acc at the end of cycle n+1 (product register).
// Backpressure: none; clr has priority and discards any in-flight product.
// Ports: sys_clk/reset_n, clr (restart), fold_en (xa/xb/coef valid this cycle),
//        centre (use xa alone), xa/xb (mirrored delay-line taps), coef, acc (running sum).
module pps_fold_fir_mac
    import pps_fold_fir_pkg::*;
#(
    parameter int DW    = 18,
    parameter int CW    = 18,
    parameter int GUARD = 4
) (
    input  logic                            sys_clk,
    input  logic                            reset_n,
    input  logic                            clr,
    input  logic                            fold_en,
    input  logic                            centre,
    input  logic signed [DW-1:0]            xa,
    input  logic signed [DW-1:0]            xb,
    input  logic signed [CW-1:0]            coef,
    output logic signed [DW+CW+GUARD:0]     acc
);

    localparam int PW = DW + CW + 1;
    localparam int AW = acc_w(DW, CW, GUARD);

    logic signed [DW:0]    pre_a;
    logic signed [DW:0]    pre_b;
    logic signed [DW:0]    pre;
    logic signed [PW-1:0]  prod;
    logic signed [PW-1:0]  prod_r;
    logic                  prod_vld;
    logic signed [AW-1:0]  acc_r;

    always_comb begin
        pre_a = {xa[DW-1], xa};
        pre_b = {xb[DW-1], xb};
        // The centre tap has no mirror partner, so it must not be doubled.
        pre   = centre ? pre_a : (pre_a + pre_b);
        prod  = pre * coef;
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_r   <= '0;
            prod_vld <= 1'b0;
            acc_r    <= '0;
        end else if (clr) begin
            prod_vld <= 1'b0;
            acc_r    <= '0;
        end else begin
            prod_r   <= prod;
            prod_vld <= fold_en;
            if (prod_vld) begin
                acc_r <= acc_r + AW'(prod_r);
            end
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/pps_fold_fir.sv
// pps_fold_fir: symmetric pulse-shaping FIR, one shared multiplier over (NTAPS+1)/2 folds per sample.
// Latency: y/y_valid update NHALF+2 sys_clk cycles after the sample strobe edge.
// Backpressure: none; a strobe during MAC aborts the running sequence and sets sticky overrun.
// Ports: sys_clk, reset_n (async active-low), sam_clk_en + x_in (sample in),
//        y + y_valid (result, held between updates), busy, overrun.
// Build option: define PPS_FOLD_FIR_OUT_SAT_EN to clamp y instead of wrapping.
module pps_fold_fir
    import pps_fold_fir_pkg::*;
#(
    parameter int DW    = 18,
    parameter int CW    = 18,
    parameter int NTAPS = 21,
    parameter int GUARD = 4
) (
    input  logic          sys_clk,
    input  logic          reset_n,
    input  logic          sam_clk_en,
    input  logic [DW-1:0] x_in,
    output logic [DW-1:0] y,
    output logic          y_valid,
    output logic          busy,
    output logic          overrun
);

    localparam int NHALF = nhalf(NTAPS);
    localparam int AW    = acc_w(DW, CW, GUARD);
    localparam int KW    = $clog2(NHALF + 1);

    logic [DW-1:0]        dline [0:NTAPS-1];
    state_t               state;
    state_t               state_nxt;
    logic [KW-1:0]        k;
    logic [KW-1:0]        k_nxt;
    logic                 fold_en;
    logic                 clr;
    logic                 ld_y;
    logic                 centre;
    logic [DW-1:0]        xa;
    logic [DW-1:0]        xb;
    logic signed [CW-1:0] coef;
    logic signed [CW-1:0] coef_tab [0:NHALF-1];
    logic signed [AW-1:0] acc;
    logic [DW-1:0]        y_nxt;
    logic                 acc_unused;

    // Coefficients rescaled from the stored 1s17 set to the configured CW.
    for (genvar g = 0; g < NHALF; g++) begin : g_coef
        localparam coef_t HRAW = coef_at(NHALF_MAX - NHALF + g);
        if (CW >= COEF_W) begin : g_up
            assign coef_tab[g] = CW'(HRAW) <<< (CW - COEF_W);
        end else begin : g_dn
            assign coef_tab[g] = CW'(HRAW >>> (COEF_W - CW));
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                dline[i] <= '0;
            end
        end else if (sam_clk_en) begin
            dline[0] <= x_in;
            for (int i = 1; i < NTAPS; i++) begin
                dline[i] <= dline[i-1];
            end
        end
    end

    // Fold k pairs the k-th newest sample with its mirror at the far end of the line.
    always_comb begin
        xa   = '0;
        xb   = '0;
        coef = '0;
        for (int i = 0; i < NHALF; i++) begin
            if (int'(k) == i) begin
                xa   = dline[i];
                xb   = dline[NTAPS-1-i];
                coef = coef_tab[i];
            end
        end
    end

    assign centre = (int'(k) == NHALF - 1);

    // MAC runs k = 0..NHALF: the last step issues no fold and lets the product register
    // drain into acc; DONE then registers y from the settled accumulator.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        fold_en   = 1'b0;
        clr       = 1'b0;
        ld_y      = 1'b0;
        case (state)
            IDLE: begin
            end
            MAC: begin
                if (int'(k) < NHALF) begin
                    fold_en = 1'b1;
                end
                if (int'(k) == NHALF) begin
                    state_nxt = DONE;
                end else begin
                    k_nxt = k + KW'(1);
                end
            end
            DONE: begin
                ld_y      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // A new sample always restarts the sequence; ld_y stays set so a strobe
        // landing in DONE still publishes the finished result.
        if (sam_clk_en) begin
            state_nxt = MAC;
            k_nxt     = '0;
            clr       = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    pps_fold_fir_mac #(
        .DW    (DW),
        .CW    (CW),
        .GUARD (GUARD)
    ) u_mac (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .clr     (clr),
        .fold_en (fold_en),
        .centre  (centre),
        .xa      (xa),
        .xb      (xb),
        .coef    (coef),
        .acc     (acc)
    );

`ifdef PPS_FOLD_FIR_OUT_SAT_EN
    logic [AW-DW-CW+1:0] acc_top;
    assign acc_top = acc[AW-1:DW+CW-2];
    // Everything from the output sign bit upward must agree, otherwise clamp by sign.
    always_comb begin
        if ((&acc_top) || !(|acc_top)) begin
            y_nxt = acc[DW+CW-2:CW-1];
        end else if (acc[AW-1]) begin
            y_nxt = {1'b1, {(DW-1){1'b0}}};
        end else begin
            y_nxt = {1'b0, {(DW-1){1'b1}}};
        end
    end
`else
    assign y_nxt = acc[DW+CW-2:CW-1];
`endif

    // Fraction and guard bits are dropped on purpose.
    assign acc_unused = ^acc;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            y       <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            y_valid <= ld_y;
            if (ld_y) begin
                y <= y_nxt;
            end
            if (sam_clk_en && state == MAC) begin
                overrun <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_pps_fold_fir.sv
// tb_pps_fold_fir: self-checking bench for pps_fold_fir with a timeline-level reference model.
// Latency: expects y_valid 13 cycles after each strobe edge.
// Backpressure: models abort/overrun when a strobe arrives before the pending result is due.
module tb_pps_fold_fir;

    logic        sys_clk;
    logic        reset_n;
    logic        sam_clk_en;
    logic [17:0] x_in;
    logic [17:0] y;
    logic        y_valid;
    logic        busy;
    logic        overrun;

    pps_fold_fir u_dut (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .sam_clk_en (sam_clk_en),
        .x_in       (x_in),
        .y          (y),
        .y_valid    (y_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Half of the 21-tap response, centre last.
    int H [0:10] = '{-372, 1123, 2261, 1407, -1805, -5448, -6116, 0, 13524, 28627, 35282};

    function automatic int hf(input int i);
        return (i <= 10) ? H[i] : H[20-i];
    endfunction

    typedef struct {
        int          due;
        logic [17:0] y;
    } exp_t;

    typedef struct {
        logic [17:0] x;
        logic [17:0] y;
    } vec_t;

    exp_t        q[$];
    longint      mx [0:20];
    logic [17:0] y_hold;
    logic        exp_ovr;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [17:0] model_y();
        longint s;
        s = 0;
        for (int i = 0; i < 21; i++) s += mx[i] * longint'(hf(i));
        s = s >>> 17;
`ifdef PPS_FOLD_FIR_OUT_SAT_EN
        if (s > 131071) s = 131071;
        else if (s < -131072) s = -131072;
`endif
        return s[17:0];
    endfunction

    task automatic model_clear();
        q.delete();
        for (int i = 0; i < 21; i++) mx[i] = 0;
        y_hold  = '0;
        exp_ovr = 1'b0;
    endtask

    // One cycle: advance to the next falling edge and check every output against the timeline.
    task automatic tick();
        logic        exp_v;
        logic        exp_busy;
        logic [17:0] ey;
        @(negedge sys_clk);
        exp_v    = 1'b0;
        exp_busy = 1'b0;
        ey       = y_hold;
        foreach (q[i]) if (q[i].due > cyc) exp_busy = 1'b1;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_v  = 1'b1;
            ey     = q[0].y;
            y_hold = q[0].y;
            void'(q.pop_front());
        end
        chk("y_valid", y_valid, exp_v);
        chk("y", y, ey);
        chk("busy", busy, exp_busy);
        chk("overrun", overrun, exp_ovr);
    endtask

    task automatic strobe(input logic [17:0] xv);
        int   e;
        exp_t ent;
        e = cyc + 1;
        sam_clk_en = 1'b1;
        x_in       = xv;
        if (q.size() > 0 && q[$].due > e) begin
            void'(q.pop_back());
            exp_ovr = 1'b1;
        end
        for (int i = 20; i > 0; i--) mx[i] = mx[i-1];
        mx[0]   = longint'(signed'(xv));
        ent.due = e + 13;
        ent.y   = model_y();
        q.push_back(ent);
        tick();
        sam_clk_en = 1'b0;
        x_in       = 18'($urandom);
    endtask

    vec_t        imp [0:20];
    logic [17:0] dc_exp;
    logic [17:0] wrap_exp;
    longint      t;
    int          gap;

    initial begin
        for (int j = 0; j < 21; j++) begin
            imp[j].x = (j == 0) ? 18'h20000 : 18'h00000;
            imp[j].y = 18'(-hf(j));
        end
        t = 0;
        for (int i = 0; i < 21; i++) t += longint'(hf(i));
        dc_exp = 18'((t * 65536) >>> 17);
        t = 0;
        for (int i = 0; i < 21; i++)
            t += (hf(i) >= 0) ? 131071 * longint'(hf(i)) : 131072 * longint'(-hf(i));
        wrap_exp = 18'(t >>> 17);

        model_clear();
        reset_n    = 1'b1;
        sam_clk_en = 1'b0;
        x_in       = '0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_y", y, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick();

        // Impulse of -1.0 walks the mirrored response out, one tap per sample.
        for (int j = 0; j < 21; j++) begin
            strobe(imp[j].x);
            repeat (15) tick();
            chk("impulse_tbl", y, imp[j].y);
        end

        // DC step of 0.5 settles once the whole line is filled.
        for (int j = 0; j < 30; j++) begin
            strobe(18'd65536);
            repeat (15) tick();
            if (j >= 20) chk("dc_settle", y, dc_exp);
        end

        // Next strobe lands exactly on the DONE cycle: both results, no overrun.
        strobe(18'($urandom));
        repeat (12) tick();
        strobe(18'($urandom));
        repeat (15) tick();
        chk("b2b_overrun", overrun, 0);

        // Full-scale samples matching each tap's sign: gain above 1.0.
        for (int j = 0; j < 21; j++) begin
            strobe((hf(20-j) >= 0) ? 18'h1FFFF : 18'h20000);
            repeat (13) tick();
        end
`ifdef PPS_FOLD_FIR_OUT_SAT_EN
        chk("sat_clamp", y, 18'h1FFFF);
`else
        chk("wrap", y, wrap_exp);
`endif

        // Random samples with periods from the DONE boundary upward.
        for (int j = 0; j < 40; j++) begin
            gap = $urandom_range(13, 20);
            strobe(18'($urandom));
            repeat (gap - 1) tick();
        end
        repeat (16) tick();

        // Overrun: second strobe 8 cycles into the first sequence.
        strobe(18'($urandom));
        repeat (7) tick();
        strobe(18'($urandom));
        repeat (15) tick();
        chk("overrun_sticky", overrun, 1);

        // Reset while the MAC is at k=5.
        strobe(18'($urandom));
        repeat (5) tick();
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_y", y, 0);
        chk("mid_rst_y_valid", y_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_overrun", overrun, 0);
        model_clear();
        tick(); tick();
        reset_n = 1'b1;
        tick();
        strobe(18'h20000);
        repeat (15) tick();
        chk("post_rst_impulse", y, 18'(-hf(0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pps_fold_fir.md
Name: pps_fold_fir

Overview:
- Parametrised, multiplier-shared, symmetric pulse-shaping FIR; successor to the fixed single-configuration PPS filter.
- Sits between the test harness input (1s17 symbols at sample rate) and its 1s17 output feeding the DAC path.
- Folds the symmetric taps with a pre-adder, then time-multiplexes one multiplier across the sys_clk cycles inside each sample period.
- Adds overrun detection and a valid strobe; tap count and widths are parameters.

Parameters:
- DW, 18, sample width (signed, 1sDW-1 format).
- CW, 18, coefficient width (signed, 1sCW-1).
- NTAPS, 21, tap count; must be odd, ≥3.
- GUARD, 4, accumulator guard bits; must satisfy ≥ ceil(log2((NTAPS+1)/2)).

Ports:
- sys_clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- sam_clk_en  in  1  one-cycle sample strobe.
- x_in  in  DW  input sample, 1s17.
- y  out  DW  filter output, 1s17, held between updates.
- y_valid  out  1  one-cycle pulse when y updates.
- busy  out  1  high while the MAC sequence runs.
- overrun  out  1  sticky; set when a strobe arrives while busy.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert): delay line, accumulator, y, y_valid, busy and overrun all go to 0; state goes to IDLE.
- Definitions:
  - NHALF = (NTAPS+1)/2.
  - Delay line x[0..NTAPS-1]; x[0] is the newest sample.
- On sam_clk_en: shift x_in into x[0] at that edge; state goes to MAC; k=0; accumulator is cleared.
- MAC state: one fold per cycle, k = 0..NHALF-1.
  - pre = x[k] + x[NTAPS-1-k], width DW+1. For the centre tap (k = NHALF-1), pre = x[k] only; it is not doubled.
  - prod = pre * h[k], width DW+CW+1.
  - acc += prod, with acc width DW+CW+1+GUARD.
  - Pipelining is allowed: a 1-stage register on pre and/or prod.
- Latency: total latency L = NHALF+2 cycles from the strobe edge, fixed regardless of pipelining choice.
- DONE: y and y_valid update on the cycle L after the strobe edge.
  - y = acc bits [DW+CW-2 : CW-1], arithmetic right shift by CW-1 (truncate toward −inf).
  - Without OUT_SAT_EN, upper bits wrap.
  - y_valid = 1 for exactly one cycle.
  - Return to IDLE.
- busy is high from the cycle after the strobe through the DONE cycle inclusive.
- The integration must guarantee the sample period ≥ L+1 sys_clk cycles.
- Strobe while busy (overrun):
  - Sample is accepted and shifted.
  - overrun is set and stays set until reset.
  - The current sequence is aborted: no y_valid, and y is unchanged.
  - MAC restarts at k=0 with a cleared accumulator.
- Strobe in the same cycle as DONE: y/y_valid for the finishing sequence still complete; the new sequence starts normally. This is not an overrun.
- x_in is sampled only on strobe cycles.

Optional Feature:
- Macro: PPS_FOLD_FIR_OUT_SAT_EN.
- Defined: if acc bits above bit DW+CW-2 (the output sign bit) are not all equal to it, y is clamped to +(2^(DW-1)-1) = 131071 or −2^(DW-1) = −131072 by sign.
- Undefined: plain truncation with wrap; no extra logic.

Decomposition:
- Package pps_fold_fir_pkg holds:
  - the coefficient array COEF_H[0:NHALF_MAX-1], CW-bit signed, default 21-tap SRRC set;
  - the state enum IDLE/MAC/DONE;
  - localparam helpers for NHALF and accumulator width.
- One natural sub-module: pps_fold_mac, holding the pre-adder, multiplier, accumulator and optional pipeline register.
- The top level keeps the delay line, FSM, output register and flags.

Test Plan:
- Impulse: reset, then one strobe with x_in = −131072 (−1.0), then 20 strobes with 0, strobes every 16 cycles.
  - y must equal −h[0], −h[1], …, −h[10], …, −h[0] (mirrored), exact.
  - y_valid fires exactly 13 cycles after each strobe.
- DC step: x_in = 65536 (0.5) held for 30 strobes.
  - y settles to floor(0.5·Σh) and is constant after 21 strobes.
  - overrun stays 0.
- Overrun: strobes 8 cycles apart.
  - overrun = 1 from the cycle after the second strobe.
  - No y_valid for the aborted sequence.
  - Next valid output matches the reference model for the shifted delay line.
- Reset mid-MAC: assert reset_n low at k=5.
  - All outputs are 0 asynchronously.
  - After release, the first strobe with x = −131072 yields y = −h[0].
- Saturation (macro defined): all taps fed 131071 with a gain > 1 coefficient set.
  - y = 131071, not wrapped.
  - With the macro undefined, y equals the wrapped model value.
- Back-to-back boundary: strobe lands exactly on the DONE cycle.
  - Both outputs are produced.
  - overrun stays 0.
